// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Combinational lookup for IF, single-port training from the resolving stage, saturating perf counters.
module branch_predictor #(
  parameter int ENTRIES   = 16,
  parameter int TAG_BITS  = 8,
  parameter int CTR_BITS  = 2,
  parameter int PERF_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          lookup_pc,
  input  logic                 lookup_en,
  output logic                 pred_hit,
  output logic                 pred_taken,
  output logic [31:0]          pred_next_pc,
  input  logic                 upd_valid,
  input  logic [31:0]          upd_pc,
  input  logic                 upd_taken,
  input  logic [31:0]          upd_target,
  input  logic                 upd_is_jump,
  input  logic                 upd_pred_taken,
  input  logic [31:0]          upd_pred_target,
  output logic                 mispredict,
  input  logic                 invalidate,
  output logic [PERF_BITS-1:0] perf_lookups,
  output logic [PERF_BITS-1:0] perf_mispredicts
);

  localparam int IDX = $clog2(ENTRIES);

  localparam logic [CTR_BITS-1:0]  CTR_ZERO  = {CTR_BITS{1'b0}};
  localparam logic [CTR_BITS-1:0]  CTR_ONE   = CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0]  CTR_MAX   = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0]  CTR_WT    = CTR_ONE << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0]  CTR_WNT   = CTR_WT - CTR_ONE;
  localparam logic [PERF_BITS-1:0] PERF_ZERO = {PERF_BITS{1'b0}};
  localparam logic [PERF_BITS-1:0] PERF_ONE  = PERF_BITS'(1);
  localparam logic [PERF_BITS-1:0] PERF_MAX  = {PERF_BITS{1'b1}};

  function automatic logic [CTR_BITS-1:0] ctr_inc(input logic [CTR_BITS-1:0] c);
    ctr_inc = (c == CTR_MAX) ? c : c + CTR_ONE;
  endfunction

  function automatic logic [CTR_BITS-1:0] ctr_dec(input logic [CTR_BITS-1:0] c);
    ctr_dec = (c == CTR_ZERO) ? c : c - CTR_ONE;
  endfunction

  function automatic logic [PERF_BITS-1:0] perf_inc(input logic [PERF_BITS-1:0] c);
    perf_inc = (c == PERF_MAX) ? c : c + PERF_ONE;
  endfunction

  logic                valid_r  [ENTRIES];
  logic [TAG_BITS-1:0] tag_r    [ENTRIES];
  logic [31:0]         target_r [ENTRIES];
  logic [CTR_BITS-1:0] ctr_r    [ENTRIES];

  logic [PERF_BITS-1:0] perf_lookups_r;
  logic [PERF_BITS-1:0] perf_mispredicts_r;

  logic [IDX-1:0]      lk_idx_s;
  logic [TAG_BITS-1:0] lk_tag_s;
  logic                lk_hit_s;
  logic                lk_taken_s;

  logic [IDX-1:0]      up_idx_s;
  logic [TAG_BITS-1:0] up_tag_s;
  logic                up_hit_s;
  logic                up_wr_s;
  logic [CTR_BITS-1:0] up_ctr_s;
  logic [31:0]         up_tgt_s;
  logic                mispredict_s;
  logic                unused_s;

  // Only the index and tag fields of the update PC address the table.
  assign unused_s = ^upd_pc;

  // Fetch-side lookup: pure function of lookup_pc and current table contents.
  always_comb begin
    lk_idx_s   = lookup_pc[IDX+1:2];
    lk_tag_s   = lookup_pc[IDX+TAG_BITS+1:IDX+2];
    lk_hit_s   = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
    lk_taken_s = lk_hit_s && ctr_r[lk_idx_s][CTR_BITS-1];
    if (lk_taken_s) begin
      pred_next_pc = target_r[lk_idx_s];
    end else begin
      pred_next_pc = lookup_pc + 32'd4;
    end
  end

  assign pred_hit   = lk_hit_s;
  assign pred_taken = lk_taken_s;

  // Resolve-side mispredict detection and next entry contents for this update.
  always_comb begin
    up_idx_s     = upd_pc[IDX+1:2];
    up_tag_s     = upd_pc[IDX+TAG_BITS+1:IDX+2];
    up_hit_s     = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);
    up_wr_s      = 1'b0;
    up_ctr_s     = ctr_r[up_idx_s];
    up_tgt_s     = target_r[up_idx_s];
    mispredict_s = 1'b0;
    if (upd_valid) begin
      mispredict_s = (upd_taken != upd_pred_taken) ||
                     (upd_taken && (upd_target != upd_pred_target));
      if (upd_is_jump) begin
        // Jumps are always taken: hit or miss, the entry ends up strongly taken.
        up_wr_s  = 1'b1;
        up_ctr_s = CTR_MAX;
        up_tgt_s = upd_target;
      end else if (up_hit_s) begin
        up_wr_s = 1'b1;
        if (upd_taken) begin
          up_ctr_s = ctr_inc(ctr_r[up_idx_s]);
          up_tgt_s = upd_target;
        end else begin
          up_ctr_s = ctr_dec(ctr_r[up_idx_s]);
        end
      end else if (upd_taken) begin
        up_wr_s  = 1'b1;
        up_ctr_s = CTR_WT;
        up_tgt_s = upd_target;
      end else begin
        up_wr_s = 1'b0;
      end
    end else begin
      mispredict_s = 1'b0;
    end
  end

  assign mispredict = mispredict_s;

  // Table storage: invalidate beats a same-cycle update; reset drops any in-flight write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= {TAG_BITS{1'b0}};
        target_r[i] <= 32'h0000_0000;
        ctr_r[i]    <= CTR_WNT;
      end
    end else if (invalidate) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i] <= 1'b0;
      end
    end else if (up_wr_s) begin
      valid_r[up_idx_s]  <= 1'b1;
      tag_r[up_idx_s]    <= up_tag_s;
      target_r[up_idx_s] <= up_tgt_s;
      ctr_r[up_idx_s]    <= up_ctr_s;
    end else begin
      valid_r[up_idx_s] <= valid_r[up_idx_s];
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_lookups_r     <= PERF_ZERO;
      perf_mispredicts_r <= PERF_ZERO;
    end else begin
      if (lookup_en) begin
        perf_lookups_r <= perf_inc(perf_lookups_r);
      end else begin
        perf_lookups_r <= perf_lookups_r;
      end
      if (mispredict_s) begin
        perf_mispredicts_r <= perf_inc(perf_mispredicts_r);
      end else begin
        perf_mispredicts_r <= perf_mispredicts_r;
      end
    end
  end

  assign perf_lookups     = perf_lookups_r;
  assign perf_mispredicts = perf_mispredicts_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (16 entries, 8-bit tags, 2-bit counters, 4-bit perf counters).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        lookup_en;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_is_jump;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic        invalidate;
  logic [3:0]  perf_lookups;
  logic [3:0]  perf_mispredicts;

  int total = 0;
  int bad   = 0;

  branch_predictor #(
    .ENTRIES(16), .TAG_BITS(8), .CTR_BITS(2), .PERF_BITS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .lookup_pc(lookup_pc), .lookup_en(lookup_en),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_is_jump(upd_is_jump),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .invalidate(invalidate),
    .perf_lookups(perf_lookups), .perf_mispredicts(perf_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic jmp,
                         input logic ptk, input logic [31:0] ptgt);
    upd_valid = v; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_is_jump = jmp; upd_pred_taken = ptk; upd_pred_target = ptgt;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic tk, input logic [31:0] npc);
    lookup_pc = pc;
    #1;
    check({tag, ".hit"},   {31'd0, pred_hit},   {31'd0, hit});
    check({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, tk});
    check({tag, ".npc"},   pred_next_pc,         npc);
  endtask

  initial begin
    rst = 1'b0; lookup_pc = 32'h100; lookup_en = 1'b0; invalidate = 1'b0;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2;
    // Reset state
    check("rst.hit", {31'd0, pred_hit}, 32'd0);
    check("rst.npc", pred_next_pc, 32'h104);
    check("rst.plk", {28'd0, perf_lookups}, 32'd0);
    check("rst.pmp", {28'd0, perf_mispredicts}, 32'd0);
    #10 rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      lookup_pc = 32'(i) * 32'd4;
      #1;
      check("rst.miss", {31'd0, pred_hit}, 32'd0);
    end
    tick();

    // Branch training: taken branch at 0x40 -> 0x80, predicted not-taken
    set_upd(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b0, 32'h44);
    lookup_pc = 32'h40;
    #1;
    check("train.misp", {31'd0, mispredict}, 32'd1);
    check("same.old_hit", {31'd0, pred_hit}, 32'd0);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    look("train1", 32'h40, 1'b1, 1'b1, 32'h80);

    // First not-taken: same-cycle lookup still sees the old (taken) counter
    set_upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b1, 32'h80);
    look("same.old", 32'h40, 1'b1, 1'b1, 32'h80);
    check("nt.misp", {31'd0, mispredict}, 32'd1);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    look("same.new", 32'h40, 1'b1, 1'b0, 32'h44);
    set_upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b1, 32'h80);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    look("train2", 32'h40, 1'b1, 1'b0, 32'h44);
    check("train.pmp", {28'd0, perf_mispredicts}, 32'd3);

    // Counter saturation: five correctly-predicted taken updates
    set_upd(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b1, 32'h80);
    #1;
    check("sat.nomisp", {31'd0, mispredict}, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    set_upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'h44);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    look("sat.ctr2", 32'h40, 1'b1, 1'b1, 32'h80);
    set_upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'h44);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    look("sat.ctr1", 32'h40, 1'b1, 1'b0, 32'h44);

    // Aliasing: 0x440 shares index 0 with 0x40 but has a different tag
    set_upd(1'b1, 32'h440, 1'b1, 32'h900, 1'b0, 1'b0, 32'h444);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    look("alias.old", 32'h40, 1'b0, 1'b0, 32'h44);
    look("alias.new", 32'h440, 1'b1, 1'b1, 32'h900);

    // Correctly predicted JAL allocates strongly taken
    set_upd(1'b1, 32'h84, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200);
    #1;
    check("jal.nomisp", {31'd0, mispredict}, 32'd0);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    look("jal", 32'h84, 1'b1, 1'b1, 32'h200);
    set_upd(1'b1, 32'h84, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    look("jal.ctr2", 32'h84, 1'b1, 1'b1, 32'h200);

    // Mispredict combinations (dropped before the edge)
    set_upd(1'b1, 32'h88, 1'b1, 32'h300, 1'b0, 1'b1, 32'h304);
    #1; check("misp.tgt", {31'd0, mispredict}, 32'd1);
    set_upd(1'b1, 32'h88, 1'b0, 32'h300, 1'b0, 1'b0, 32'h304);
    #1; check("misp.ntok", {31'd0, mispredict}, 32'd0);
    set_upd(1'b0, 32'h88, 1'b1, 32'h300, 1'b0, 1'b0, 32'h304);
    #1; check("misp.novld", {31'd0, mispredict}, 32'd0);

    // Miss, not taken: no allocation
    set_upd(1'b1, 32'h88, 1'b0, 32'h300, 1'b0, 1'b0, 32'h8c);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    look("miss.nt", 32'h88, 1'b0, 1'b0, 32'h8c);

    // Invalidate wins over a same-cycle allocating update
    invalidate = 1'b1;
    set_upd(1'b1, 32'hC0, 1'b1, 32'h500, 1'b0, 1'b0, 32'hC4);
    tick();
    invalidate = 1'b0;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    look("inv.upd", 32'hC0, 1'b0, 1'b0, 32'hC4);
    look("inv.old", 32'h84, 1'b0, 1'b0, 32'h88);

    // Perf lookup counter saturates at 15
    check("plk.zero", {28'd0, perf_lookups}, 32'd0);
    lookup_en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("plk.three", {28'd0, perf_lookups}, 32'd3);
    for (int i = 0; i < 17; i++) tick();
    lookup_en = 1'b0;
    check("plk.sat", {28'd0, perf_lookups}, 32'd15);

    // Asynchronous reset mid-update
    set_upd(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b0, 32'h44);
    tick();
    look("pre.rst", 32'h40, 1'b1, 1'b1, 32'h80);
    #2 rst = 1'b0;
    #1;
    check("arst.hit", {31'd0, pred_hit}, 32'd0);
    check("arst.plk", {28'd0, perf_lookups}, 32'd0);
    #5 rst = 1'b1;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    look("post.rst", 32'h40, 1'b0, 1'b0, 32'h44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
